// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: integer+fractional divisor with a carry
// accumulator, producing oversample and bit ticks with live reprogramming.
module baud_gen_frac #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              cfg_load,
    input  logic              sync_clear,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              cfg_pending,
    output logic              cfg_err
);

    localparam int CNT_W = DIV_W + 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam longint unsigned CLK_L   = CLK_FREQ;
    localparam longint unsigned DIVISOR = BAUD_RATE * OVERSAMPLE;
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(CLK_L / DIVISOR);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'((CLK_L << FRAC_W) / DIVISOR);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  sh_int_q,   sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q,  sh_frac_d;
    logic [CNT_W-1:0]  len_q,      len_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [FRAC_W-1:0] acc_q,      acc_d;
    logic [OS_W-1:0]   os_cnt_q,   os_cnt_d;
    logic              os_tick_q,  os_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              pend_q,     pend_d;
    logic              err_q,      err_d;

    logic              cfg_ok_s;
    logic              terminal_s;
    logic [FRAC_W:0]   sum_s;

    assign cfg_ok_s   = cfg_load && (div_int >= DIV_W'(2));
    assign terminal_s = (cnt_q == (len_q - CNT_W'(1)));
    assign sum_s      = {1'b0, acc_q} + {1'b0, act_frac_q};

    // Next-state: sync_clear and idle loads restart phase; otherwise count periods.
    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        pend_d     = pend_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        err_d      = cfg_load && !cfg_ok_s;

        if (sync_clear) begin
            cnt_d    = '0;
            acc_d    = '0;
            os_cnt_d = '0;
            pend_d   = 1'b0;
            if (cfg_ok_s) begin
                act_int_d  = div_int;
                act_frac_d = div_frac;
                len_d      = {1'b0, div_int};
            end else if (pend_q) begin
                act_int_d  = sh_int_q;
                act_frac_d = sh_frac_q;
                len_d      = {1'b0, sh_int_q};
            end else begin
                len_d      = {1'b0, act_int_q};
            end
        end else if (cfg_ok_s && !enable) begin
            act_int_d  = div_int;
            act_frac_d = div_frac;
            len_d      = {1'b0, div_int};
            cnt_d      = '0;
            acc_d      = '0;
            os_cnt_d   = '0;
            pend_d     = 1'b0;
        end else if (enable) begin
            if (cfg_ok_s) begin
                sh_int_d  = div_int;
                sh_frac_d = div_frac;
                pend_d    = 1'b1;
            end else begin
                sh_int_d  = sh_int_q;
            end
            if (terminal_s) begin
                os_tick_d = 1'b1;
                cnt_d     = '0;
                if (os_cnt_q == OS_LAST) begin
                    os_cnt_d   = '0;
                    bit_tick_d = 1'b1;
                end else begin
                    os_cnt_d   = os_cnt_q + OS_W'(1);
                end
                // A load landing on this very edge defers to the next period end.
                if (pend_q && !cfg_ok_s) begin
                    act_int_d  = sh_int_q;
                    act_frac_d = sh_frac_q;
                    len_d      = {1'b0, sh_int_q};
                    acc_d      = '0;
                    pend_d     = 1'b0;
                end else begin
                    acc_d = sum_s[FRAC_W-1:0];
                    len_d = {1'b0, act_int_q} + CNT_W'(sum_s[FRAC_W]);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_int_q  <= DEF_INT;
            act_frac_q <= DEF_FRAC;
            sh_int_q   <= DEF_INT;
            sh_frac_q  <= DEF_FRAC;
            len_q      <= {1'b0, DEF_INT};
            cnt_q      <= '0;
            acc_q      <= '0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

    assign os_tick     = os_tick_q;
    assign bit_tick    = bit_tick_q;
    assign cfg_pending = pend_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: expected tick times come from the
// closed-form sum of fractional periods, checked by an independent monitor.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] div_int = 16'd0;
    logic [3:0]  div_frac = 4'd0;
    logic        cfg_load = 1'b0;
    logic        sync_clear = 1'b0;
    logic        os_tick, bit_tick, cfg_pending, cfg_err;

    baud_gen_frac dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .div_int(div_int), .div_frac(div_frac),
        .cfg_load(cfg_load), .sync_clear(sync_clear),
        .os_tick(os_tick), .bit_tick(bit_tick),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; bit b; } exp_t;
    exp_t exp_q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int err_exp = -1;
    int base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Sum of the first n periods: n*int plus the carries out of (n-1) accumulations.
    function automatic int t_of(input int b, input int i, input int f, input int n);
        return b + n * i + (((n - 1) * f) >> 4);
    endfunction

    task automatic push(input int c, input bit b);
        exp_t e;
        e.cyc = c;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic push_run(input int b, input int i, input int f, input int n1, input int n2);
        for (int n = n1; n <= n2; n++) push(t_of(b, i, f, n), (n % 16) == 0);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_empty(input string nm);
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic load_idle(input int i, input int f);
        enable = 1'b0; cfg_load = 1'b1; div_int = 16'(i); div_frac = 4'(f);
        @(negedge clk);
        cfg_load = 1'b0; enable = 1'b1; base = cyc;
        check_empty("missing_ticks");
    endtask

    // Monitor: every observed tick must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (os_tick) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_os_tick", cyc, -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("os_tick_cycle", cyc, e.cyc);
                    chk("bit_tick", bit_tick, e.b);
                end
            end else if (bit_tick) begin
                chk("bit_tick_without_os", bit_tick, 0);
            end
            if (cfg_err && cyc != err_exp) chk("stray_cfg_err", cyc, err_exp);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, ri, rf;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {os_tick, bit_tick, cfg_pending, cfg_err}, 0);

        // Defaults 325.5 from reset release.
        reset_n = 1'b1; base = cyc;
        push_run(base, 325, 8, 1, 34);
        last = t_of(base, 325, 8, 34);
        wait_until(last);

        // Integer divisor first, then random fractional divisors.
        for (int r = 0; r < 4; r++) begin
            ri = (r == 0) ? 4 : $urandom_range(2, 12);
            rf = (r == 0) ? 0 : $urandom_range(0, 15);
            load_idle(ri, rf);
            push_run(base, ri, rf, 1, 40);
            last = t_of(base, ri, rf, 40);
            wait_until(last);
        end

        // Live reload from 10 to 6, then a rejected load.
        load_idle(10, 0);
        for (int n = 1; n <= 4; n++) push(base + 10 * n, 1'b0);
        for (int n = 5; n <= 20; n++) push(base + 40 + 6 * (n - 4), (n % 16) == 0);
        wait_until(base + 34);
        cfg_load = 1'b1; div_int = 16'd6; div_frac = 4'd0;
        @(negedge clk);
        cfg_load = 1'b0;
        while (cyc < base + 40) begin
            chk("cfg_pending_set", cfg_pending, 1);
            @(negedge clk);
        end
        chk("cfg_pending_clear", cfg_pending, 0);
        wait_until(base + 60);
        cfg_load = 1'b1; div_int = 16'd1; err_exp = cyc + 1;
        @(negedge clk);
        cfg_load = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        @(negedge clk);
        chk("cfg_err_one_cycle", cfg_err, 0);
        chk("invalid_no_pending", cfg_pending, 0);
        err_exp = -1;
        wait_until(base + 136);

        // Freeze for 7 cycles, then sync_clear on a terminal count.
        load_idle(10, 0);
        push(base + 10, 1'b0);
        for (int n = 2; n <= 4; n++) push(base + 10 * n + 7, 1'b0);
        wait_until(base + 13);
        enable = 1'b0;
        wait_until(base + 20);
        enable = 1'b1;
        wait_until(base + 56);
        for (int k = 1; k <= 17; k++) push(base + 57 + 10 * k, k == 16);
        sync_clear = 1'b1;
        @(negedge clk);
        sync_clear = 1'b0;
        chk("no_tick_on_sync_clear", os_tick, 0);
        wait_until(base + 57 + 170);

        // Reset while a config is pending.
        load_idle(10, 0);
        for (int n = 1; n <= 3; n++) push(base + 10 * n, 1'b0);
        wait_until(base + 34);
        cfg_load = 1'b1; div_int = 16'd5;
        @(negedge clk);
        cfg_load = 1'b0;
        chk("pending_before_reset", cfg_pending, 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {os_tick, bit_tick, cfg_pending, cfg_err}, 0);
        check_empty("ticks_before_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1; enable = 1'b1; base = cyc;
        push_run(base, 325, 8, 1, 17);
        @(negedge clk);
        chk("pending_lost_after_reset", cfg_pending, 0);
        last = t_of(base, 325, 8, 17);
        wait_until(last + 2);
        check_empty("missing_ticks_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
